bus_arbiter: RTL and testbench

- Two-master shared-bus arbiter. It sits directly upstream of the slave address decoder.
- Grants the bus to master 0 or master 1 through a registered state machine.
- Muxes the granted master's request, write strobe, address and write data onto the shared bus signals (m_req, m_wr, m_address, m_dout).
- The decoder consumes m_req/m_address to pick the slave.

---
 rtl/bus_pkg.sv | 26 ++
 rtl/bus_mux2.sv | 43 ++++
 rtl/bus_arbiter.sv | 112 +++++++++++
 tb/tb_bus_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, default widths and the
// slave address map that the downstream address decoder also uses.
package bus_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_M0   = 2'd1;
    localparam logic [1:0] ST_M1   = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        M0_GRANT = ST_M0,
        M1_GRANT = ST_M1
    } arb_state_e;

    // Slave windows seen by the decoder that sits behind the arbiter.
    localparam logic [15:0] SLV0_BASE = 16'h0000;
    localparam logic [15:0] SLV0_LAST = 16'h3FFF;
    localparam logic [15:0] SLV1_BASE = 16'h4000;
    localparam logic [15:0] SLV1_LAST = 16'h7FFF;
    localparam logic [15:0] SLV2_BASE = 16'h8000;
    localparam logic [15:0] SLV2_LAST = 16'hFFFF;

endpackage

// File: rtl/bus_mux2.sv
// Combinational 2:1 bus mux of {req, wr, address, dout}; drives zero on every
// field when neither select is set so an idle bus never carries stale data.
module bus_mux2
    import bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sel0_i,
    input  logic              sel1_i,
    input  logic              req0_i,
    input  logic              wr0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] dout0_i,
    input  logic              req1_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] dout1_i,
    output logic              req_o,
    output logic              wr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] dout_o
);

    always_comb begin
        req_o  = 1'b0;
        wr_o   = 1'b0;
        addr_o = '0;
        dout_o = '0;
        if (sel0_i) begin
            req_o  = req0_i;
            wr_o   = wr0_i;
            addr_o = addr0_i;
            dout_o = dout0_i;
        end else if (sel1_i) begin
            req_o  = req1_i;
            wr_o   = wr1_i;
            addr_o = addr1_i;
            dout_o = dout1_i;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master shared-bus arbiter with registered grants and a grant-driven bus mux.
// Define ARB_TENURE_EN to force hand-over after MAX_TENURE cycles when the other master waits.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MAX_TENURE = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [DATA_W-1:0] m0_dout,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [DATA_W-1:0] m1_dout,
    output logic              m0_grant,
    output logic              m1_grant,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_dout
);

    if (MAX_TENURE < 2 || MAX_TENURE > 255) begin : g_bad_tenure
        $error("bus_arbiter: MAX_TENURE must lie in 2..255");
    end

    arb_state_e state_q, state_d;
    logic       m0_grant_q, m1_grant_q;
    logic       tenure_up;

`ifdef ARB_TENURE_EN
    logic [7:0] tenure_q, tenure_d;

    assign tenure_up = (tenure_q == 8'(MAX_TENURE - 1));

    // Count only while ownership is unchanged; saturate at the limit so the
    // owner keeps the bus until the other master actually asks for it.
    always_comb begin
        tenure_d = 8'd0;
        if (state_q != IDLE && state_d == state_q)
            tenure_d = tenure_up ? tenure_q : tenure_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) tenure_q <= 8'd0;
        else       tenure_q <= tenure_d;
    end
`else
    assign tenure_up = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (m0_req)      state_d = M0_GRANT;
                else if (m1_req) state_d = M1_GRANT;
            end
            M0_GRANT: begin
                if (m1_req && (!m0_req || tenure_up)) state_d = M1_GRANT;
                else if (!m0_req)                     state_d = IDLE;
            end
            M1_GRANT: begin
                if (m0_req && (!m1_req || tenure_up)) state_d = M0_GRANT;
                else if (!m1_req)                     state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants are registered alongside the state so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            m0_grant_q <= 1'b0;
            m1_grant_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            m0_grant_q <= (state_d == M0_GRANT);
            m1_grant_q <= (state_d == M1_GRANT);
        end
    end

    assign m0_grant = m0_grant_q;
    assign m1_grant = m1_grant_q;

    bus_mux2 #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel0_i  (m0_grant_q),
        .sel1_i  (m1_grant_q),
        .req0_i  (m0_req),
        .wr0_i   (m0_wr),
        .addr0_i (m0_address),
        .dout0_i (m0_dout),
        .req1_i  (m1_req),
        .wr1_i   (m1_wr),
        .addr1_i (m1_address),
        .dout1_i (m1_dout),
        .req_o   (m_req),
        .wr_o    (m_wr),
        .addr_o  (m_address),
        .dout_o  (m_dout)
    );

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios then random traffic,
// every cycle compared against an ownership model (tenure limit when ARB_TENURE_EN).
module tb_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_wr, m1_req, m1_wr;
    logic [AW-1:0] m0_address, m1_address;
    logic [DW-1:0] m0_dout, m1_dout;
    logic          m0_grant, m1_grant, m_req, m_wr;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_dout;

    int vectors     = 0;
    int miscompares = 0;
    int owner       = -1;   // -1: nobody, 0/1: master index
    int tenure      = 0;    // cycles the current owner has already held the bus

    always #5 clk = ~clk;

    bus_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_TENURE (MT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_req     (m0_req),
        .m0_wr      (m0_wr),
        .m0_address (m0_address),
        .m0_dout    (m0_dout),
        .m1_req     (m1_req),
        .m1_wr      (m1_wr),
        .m1_address (m1_address),
        .m1_dout    (m1_dout),
        .m0_grant   (m0_grant),
        .m1_grant   (m1_grant),
        .m_req      (m_req),
        .m_wr       (m_wr),
        .m_address  (m_address),
        .m_dout     (m_dout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [49:0] exp_bus;
        exp_bus = '0;
        if (owner == 0) exp_bus = {m0_req, m0_wr, m0_address, m0_dout};
        if (owner == 1) exp_bus = {m1_req, m1_wr, m1_address, m1_dout};
        chk("grants", 64'({m1_grant, m0_grant}), 64'({owner == 1, owner == 0}));
        chk("bus", 64'({m_req, m_wr, m_address, m_dout}), 64'(exp_bus));
        chk("onehot", 64'(m0_grant & m1_grant), 64'd0);
    endtask

    // Ownership rules: the idle bus goes to the lowest requesting master; an owner
    // keeps the bus while requesting, unless the other waits and tenure is exhausted.
    task automatic model_edge();
        logic [1:0] rq;
        int         nxt;
        bit         limit;
        rq    = {m1_req, m0_req};
        limit = 1'b0;
`ifdef ARB_TENURE_EN
        limit = (tenure == MT - 1);
`endif
        if (reset) begin
            owner  = -1;
            tenure = 0;
        end else begin
            nxt = owner;
            if (owner < 0) begin
                nxt = rq[0] ? 0 : (rq[1] ? 1 : -1);
            end else if (rq[1-owner] && (!rq[owner] || limit)) begin
                nxt = 1 - owner;
            end else if (!rq[owner]) begin
                nxt = -1;
            end
            tenure = (nxt < 0 || nxt != owner) ? 0 : ((tenure == MT - 1) ? tenure : tenure + 1);
            owner  = nxt;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        {m0_req, m0_wr, m1_req, m1_wr} = 4'b0;
        m0_address = '0; m1_address = '0; m0_dout = '0; m1_dout = '0;
        @(posedge clk);
        model_edge();
        #1;
        cycle();
        cycle();
        chk("reset_m_req", 64'(m_req), 64'd0);
        chk("reset_addr", 64'(m_address), 64'h0000);

        // Simultaneous request from idle, then direct hand-over.
        reset = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        m0_address = 16'h0100; m1_address = 16'h7010;
        cycle();
        chk("simul_m0_grant", 64'(m0_grant), 64'd1);
        chk("simul_m0_addr", 64'(m_address), 64'h0100);
        m0_req = 1'b0;
        cycle();
        chk("handover_m1_grant", 64'(m1_grant), 64'd1);
        chk("handover_addr", 64'(m_address), 64'h7010);

        // m1 holds while m0 waits (alternation instead when tenure is enabled).
        m0_req = 1'b1; m0_dout = 32'h0BAD_F00D;
        repeat (40) cycle();
`ifndef ARB_TENURE_EN
        chk("nonpreempt_m1", 64'(m1_grant), 64'd1);
`endif

        // Release to idle from m0.
        m1_req = 1'b0;
        repeat (3) cycle();
        m0_req = 1'b0;
        cycle();
        chk("release_idle", 64'({m0_grant, m1_grant, m_req, m_wr}), 64'd0);

        // Reset in the middle of an m0 write.
        m0_req = 1'b1; m0_wr = 1'b1; m0_dout = 32'hDEADBEEF;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        chk("midreset_dout", 64'(m_dout), 64'd0);
        reset = 1'b0; m0_req = 1'b0; m0_wr = 1'b0; m1_req = 1'b1;
        cycle();
        chk("after_reset_m1", 64'(m1_grant), 64'd1);

        // Both requesting for a long stretch, then m0 alone.
        m1_req = 1'b0; m0_req = 1'b1;
        cycle();
        m1_req = 1'b1;
        repeat (20) cycle();
        m1_req = 1'b0;
        repeat (20) cycle();

        // Random traffic with sticky requests and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) m0_req = ~m0_req;
            if ($urandom_range(3) == 0) m1_req = ~m1_req;
            m0_wr      = 1'($urandom);
            m1_wr      = 1'($urandom);
            m0_address = AW'($urandom);
            m1_address = AW'($urandom);
            m0_dout    = $urandom;
            m1_dout    = $urandom;
            reset      = ($urandom_range(63) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
